// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: extension mode
// codes and the pipeline occupancy state encoding.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN  = 2'd0;
    localparam logic [1:0] MODE_ZERO  = 2'd1;
    localparam logic [1:0] MODE_UPPER = 2'd2;
    localparam logic [1:0] MODE_BROFF = 2'd3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage : imm_ext_pkg

// File: rtl/imm_extend_core.sv
// Combinational immediate widener: IN_W-bit immediate -> OUT_W bits in
// sign, zero, upper (lui) or branch-offset (sign, then << 2) form.
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
)
(
    input  logic [IN_W-1:0]  i_imm,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_data
);

    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_broff;

    assign w_sign  = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
    assign w_zero  = {{(OUT_W-IN_W){1'b0}}, i_imm};
    assign w_upper = {i_imm, {(OUT_W-IN_W){1'b0}}};
    // Branch offset is a word offset: drop the top two sign bits.
    assign w_broff = {w_sign[OUT_W-3:0], 2'b00};

    // Select the extended form requested by the mode field.
    always_comb begin
        o_data = w_sign;
        case (i_mode)
            MODE_SIGN:  o_data = w_sign;
            MODE_ZERO:  o_data = w_zero;
            MODE_UPPER: o_data = w_upper;
            MODE_BROFF: o_data = w_broff;
            default:    o_data = w_sign;
        endcase
    end

endmodule : imm_extend_core

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage with valid/ready handshake and a
// one-entry skid buffer. in_ready depends only on registered state, so
// there is no combinational path from out_ready to in_ready.
// Optional feature macro: IMM_EXT_STALL_CNT_EN adds a saturating stall_cnt
// output counting cycles with out_valid && !out_ready.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | result in output register, skid empty
// FULL  | output and skid both hold results, in_ready=0
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (IN_W < 1 || IN_W > OUT_W - 2 || CNT_W < 1) begin : g_bad_param
        $error("imm_extend_pipe: need 1 <= IN_W <= OUT_W-2 and CNT_W >= 1");
    end

    state_e           r_state;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_skid_full;

    logic [OUT_W-1:0] w_ext;
    logic             w_in_xfer;
    logic             w_out_xfer;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm  (in_imm),
        .i_mode (in_mode),
        .o_data (w_ext)
    );

    assign in_ready   = !r_skid_full;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign w_in_xfer  = in_valid && !r_skid_full;
    assign w_out_xfer = r_out_valid && out_ready;

    // Occupancy FSM: steer extended results into the output or skid register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_skid_data <= '0;
            r_skid_full <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_out_data  <= w_ext;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_out_data <= w_ext;
                    end else if (w_in_xfer) begin
                        r_skid_data <= w_ext;
                        r_skid_full <= 1'b1;
                        r_state     <= FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        r_out_data  <= r_skid_data;
                        r_skid_full <= 1'b0;
                        r_state     <= ONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_skid_full <= 1'b0;
                    r_state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef IMM_EXT_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Count backpressure cycles, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`endif

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a queue-based occupancy model checked on every
// falling edge, plus directed vectors with literal expected values.
// Build with IMM_EXT_STALL_CNT_EN defined to exercise the stall counter.
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
`ifdef IMM_EXT_STALL_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [1:0]       in_mode = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef IMM_EXT_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Arithmetic reference for the four extension modes.
    function automatic logic [OUT_W-1:0] model_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        longint s;
        longint t;
        s = longint'(imm);
        if (s >= (longint'(1) << (IN_W - 1)))
            s = s - (longint'(1) << IN_W);
        case (mode)
            2'd0:    t = s;
            2'd1:    t = longint'(imm);
            2'd2:    t = longint'(imm) << (OUT_W - IN_W);
            default: t = s * 4;
        endcase
        return t[OUT_W-1:0];
    endfunction

    // Model: ordered list of results held in the stage (at most two).
    logic [OUT_W-1:0] m_q[$];
    int               m_stall = 0;
    bit               m_started = 0;

    always @(negedge clock) begin
        bit in_x;
        bit out_x;
        if (m_started) begin
            chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
            if (m_q.size() > 0)
                chk("out_data", 64'(out_data), 64'(m_q[0]));
`ifdef IMM_EXT_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
        if (!reset) begin
            m_q.delete();
            m_stall   = 0;
            m_started = 1;
        end else if (m_started) begin
            in_x  = in_valid && (m_q.size() < 2);
            out_x = (m_q.size() > 0) && out_ready;
            if ((m_q.size() > 0) && !out_ready && m_stall < (2**CNT_W - 1))
                m_stall++;
            if (out_x)
                void'(m_q.pop_front());
            if (in_x)
                m_q.push_back(model_ext(in_imm, in_mode));
        end
    end

    task automatic drive(input bit v, input logic [IN_W-1:0] imm, input logic [1:0] mode, input bit rdy);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(0, '0, 2'd0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_data", 64'(out_data), 64'h0);

        // Mode vectors, streaming through with out_ready=1.
        drive(1, 16'h8001, 2'd0, 1); tick();
        chk("sign_8001", 64'(out_data), 64'hFFFF8001);
        chk("sign_valid", 64'(out_valid), 64'h1);
        drive(1, 16'h8001, 2'd1, 1); tick();
        chk("zero_8001", 64'(out_data), 64'h00008001);
        drive(1, 16'h1234, 2'd2, 1); tick();
        chk("upper_1234", 64'(out_data), 64'h12340000);
        drive(1, 16'hFFFF, 2'd3, 1); tick();
        chk("broff_ffff", 64'(out_data), 64'hFFFFFFFC);
        drive(1, 16'h7FFF, 2'd3, 1); tick();
        chk("broff_7fff", 64'(out_data), 64'h0001FFFC);
        drive(0, '0, 2'd0, 1); tick();
        chk("drain_valid", 64'(out_valid), 64'h0);

        // Backpressure: A then B with out_ready=0.
        drive(1, 16'h0001, 2'd1, 0); tick();
        chk("bp_a_ready", 64'(in_ready), 64'h1);
        drive(1, 16'h0002, 2'd1, 0); tick();
        chk("bp_full_ready", 64'(in_ready), 64'h0);
        chk("bp_hold_a", 64'(out_data), 64'h1);
        drive(1, 16'h0003, 2'd1, 0); tick();   // refused while full
        chk("bp_still_a", 64'(out_data), 64'h1);
        drive(0, '0, 2'd0, 1); tick();
        chk("bp_out_b", 64'(out_data), 64'h2);
        chk("bp_b_valid", 64'(out_valid), 64'h1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Streaming: 8 back-to-back inputs.
        for (int i = 0; i < 8; i++) begin
            drive(1, 16'(16'h0100 + i), 2'(i % 4), 1);
            tick();
            chk("stream_ready", 64'(in_ready), 64'h1);
            chk("stream_valid", 64'(out_valid), 64'h1);
        end
        drive(0, '0, 2'd0, 1); tick();

        // Fill, then a reset glitch that misses every rising edge.
        drive(1, 16'hA5A5, 2'd1, 0); tick();
        drive(1, 16'h5A5A, 2'd1, 0); tick();
        drive(0, '0, 2'd0, 0);
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        chk("glitch_full", 64'(in_ready), 64'h0);
        chk("glitch_data", 64'(out_data), 64'h0000A5A5);

        // Synchronous reset while full; in_valid must be ignored.
        reset = 1'b0;
        drive(1, 16'h1111, 2'd0, 0);
        tick();
        reset = 1'b1;
        drive(0, '0, 2'd0, 0);
        chk("rstfull_valid", 64'(out_valid), 64'h0);
        chk("rstfull_ready", 64'(in_ready), 64'h1);
        chk("rstfull_data", 64'(out_data), 64'h0);
        tick();
        chk("rstfull_idle", 64'(out_valid), 64'h0);

        // Long stall: one result held for 20 cycles.
        drive(1, 16'h00C3, 2'd0, 0); tick();
        drive(0, '0, 2'd0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_hold", 64'(out_data), 64'h000000C3);
`ifdef IMM_EXT_STALL_CNT_EN
        chk("stall_sat", 64'(stall_cnt), 64'hF);
`endif
        drive(0, '0, 2'd0, 1); tick();
        tick();
        chk("final_empty", 64'(out_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imm_extend_pipe

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension stage for the pipelined MIPS datapath, placed between decode and the ID/EX operand path.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper, or branch-offset.
- Registered output with a valid/ready handshake and a one-entry skid buffer, so downstream stalls never drop or duplicate an immediate.

Parameters:
- IN_W, 16, immediate input width. Must satisfy 1 <= IN_W <= OUT_W-2.
- OUT_W, 32, extended output width.
- CNT_W, 16, width of the optional stall counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: state clears on a rising clock edge while reset==0.
- in_valid  in  1  an upstream immediate is present.
- in_ready  out  1  the stage can accept an input this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  0=SIGN, 1=ZERO, 2=UPPER, 3=BROFF.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  downstream consumes the result this cycle.
- out_data  out  OUT_W  extended immediate.
- stall_cnt  out  CNT_W  present only with IMM_EXT_STALL_CNT_EN.

Behaviour:
- Extension function (combinational, applied on capture):
  - SIGN: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - ZERO: {(OUT_W-IN_W){0}, imm}.
  - UPPER: imm placed in bits [OUT_W-1 : OUT_W-IN_W], low bits zero. Implements lui for 16/32.
  - BROFF: SIGN result shifted left by 2, top two bits discarded.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- State:
  - Output register: out_data, out_valid.
  - Skid register: skid_data, skid_full.
- States: EMPTY (out_valid=0, skid_full=0), ONE (out_valid=1, skid_full=0), FULL (out_valid=1, skid_full=1).
- in_ready = !skid_full, registered-derived. There is no combinational path from out_ready to in_ready.
- Transitions:
  - EMPTY + input: capture into out; go to ONE.
  - ONE + input + output: replace out with the new result; stay in ONE.
  - ONE + input, no output: capture into skid; go to FULL.
  - ONE + output, no input: go to EMPTY.
  - FULL + output: move skid into out; go to ONE. No input is possible since in_ready=0.
  - FULL, no output: hold all state.
- Latency: 1 cycle from input transfer to out_valid when the stage is EMPTY.
- Throughput: 1 result per cycle while out_ready=1.
- Ordering: strictly FIFO.
- While out_valid=1 and out_ready=0, out_data must be stable.
- Reset (including mid-operation): out_valid=0, skid_full=0, out_data=0, skid_data=0, stall_cnt=0. in_ready reads 1 from the cycle after reset deasserts.
  - Any in-flight result is discarded.
  - in_valid is ignored while reset==0.
- in_mode and in_imm are sampled only on the input-transfer edge.

Optional Feature:
- Macro: IMM_EXT_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 on every cycle with out_valid && !out_ready.
  - Saturates at all-ones; no wrap.
  - Cleared by reset only.
- Undefined: no stall_cnt port, no counter logic. The rest of the behaviour is identical.

Decomposition:
- Package imm_ext_pkg holds:
  - mode constants MODE_SIGN=2'd0, MODE_ZERO=2'd1, MODE_UPPER=2'd2, MODE_BROFF=2'd3;
  - the state encodings EMPTY/ONE/FULL.
- One natural sub-module, imm_extend_core: purely combinational (imm, mode) -> OUT_W result, parametrised IN_W/OUT_W.
  - Instantiated once, feeding both the out and skid capture paths.

Test Plan:
- SIGN, 16->32: in_imm=16'h8001 with out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001. ZERO with the same imm -> 32'h00008001.
- UPPER: imm=16'h1234 -> 32'h12340000. BROFF: imm=16'hFFFF -> 32'hFFFFFFFC; imm=16'h7FFF -> 32'h0001FFFC.
- Backpressure: push A=16'h0001 and B=16'h0002 on back-to-back cycles with out_ready=0 -> in_ready=0 after B and out_data holds A. Then out_ready=1 -> outputs A, then B, with no loss or duplication.
- Streaming: 8 consecutive inputs with out_ready=1 -> 8 consecutive valid outputs in order, in_ready held at 1 throughout.
- Reset in FULL state: assert reset=0 for one edge -> out_valid=0 and in_ready=1 afterwards, with no stale output. Confirm an asynchronous pulse of reset that does not span a rising edge has no effect.
- With IMM_EXT_STALL_CNT_EN and CNT_W=4: hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=4'hF, saturated. Without the macro, the port is absent.
